// File: rtl/rr_encode_arbiter.sv
// rtl/rr_encode_arbiter.sv - round-robin arbiter with a registered one-hot grant and a binary grant index
// The encoder relies on a one-hot (or zero) input, which the arbiter's grant register always holds.

module rr_encode_arbiter_encode #(
    parameter int width = 8,
    localparam int m = $clog2(width)
) (
    input  logic [width-1:0] onehot,
    output logic [m-1:0]     idx
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < width; i++) begin
            if (onehot[i]) idx = idx | m'(i);
        end
    end
endmodule

module rr_encode_arbiter #(
    parameter int width = 8,
    localparam int m = $clog2(width)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] Req,
    input  logic             GntReady,
    output logic             GntValid,
    output logic [width-1:0] Gnt,
    output logic [m-1:0]     GntIdx
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state, nxt_state;
    logic [m-1:0]     ptr, nxt_ptr, pn;
    logic [width-1:0] gnt, nxt_gnt, cand_idle, cand_busy;

    // First requester found scanning upward from p, wrapping at width-1.
    function automatic logic [width-1:0] rr(input logic [width-1:0] r, input logic [m-1:0] p);
        logic [width-1:0] g;
        logic             found;
        logic [m:0]       pos;
        g     = '0;
        found = 1'b0;
        for (int j = 0; j < width; j++) begin
            pos = {1'b0, p} + (m+1)'(j);
            if (pos >= (m+1)'(width)) pos = pos - (m+1)'(width);
            if (!found && r[pos[m-1:0]]) begin
                g[pos[m-1:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return g;
    endfunction

    rr_encode_arbiter_encode #(.width(width)) u_encode (
        .onehot (gnt),
        .idx    (GntIdx)
    );

    assign Gnt      = gnt;
    assign GntValid = (state == BUSY);

    always_comb begin
        pn        = (GntIdx == m'(width - 1)) ? '0 : GntIdx + m'(1);
        cand_idle = rr(Req, ptr);
        cand_busy = rr(Req, pn);
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_gnt   = gnt;
        case (state)
            IDLE: begin
                if (|Req) begin
                    nxt_gnt   = cand_idle;
                    nxt_state = BUSY;
                end
            end
            default: begin
                // Stalled grants are frozen; Req is only looked at on a handshake.
                if (GntReady) begin
                    nxt_ptr = pn;
                    if (|cand_busy) begin
                        nxt_gnt = cand_busy;
                    end else begin
                        nxt_gnt   = '0;
                        nxt_state = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= nxt_state;
            ptr   <= nxt_ptr;
            gnt   <= nxt_gnt;
        end
    end
endmodule
